// File: rtl/bpsk_symbol_framer_if.sv
// rtl/bpsk_symbol_framer_if.sv - symbol-in / frame-out handshake bundle for the BPSK symbol framer
//
// Symbol side : sym_in, sym_valid, frame_start (upstream -> framer), sym_ready (framer -> upstream)
// Frame side  : frame_out, frame_valid, frame_err, frame_abort (framer -> demodulator),
//               frame_ready (demodulator -> framer)
// master = environment (symbol source and frame sink), slave = framer
interface bpsk_symbol_framer_if #(
    parameter int N = 12
) ();
    logic [1:0]     sym_in;
    logic           sym_valid;
    logic           frame_start;
    logic           sym_ready;
    logic [2*N-1:0] frame_out;
    logic           frame_valid;
    logic           frame_ready;
    logic           frame_err;
    logic           frame_abort;

    modport master (
        output sym_in, sym_valid, frame_start, frame_ready,
        input  sym_ready, frame_out, frame_valid, frame_err, frame_abort
    );

    modport slave (
        input  sym_in, sym_valid, frame_start, frame_ready,
        output sym_ready, frame_out, frame_valid, frame_err, frame_abort
    );
endinterface

// File: rtl/bpsk_symbol_framer.sv
// rtl/bpsk_symbol_framer.sv - aligns BPSK symbols on frame_start and packs N of them into a 2N-bit word
//
// Ports:
//   clk   - clock, all logic on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of bpsk_symbol_framer_if: symbol handshake in, double-buffered frame out
//           (symbol k lands at frame_out[2k+1:2k], first received symbol is k=0)
module bpsk_symbol_framer #(
    parameter int N = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    bpsk_symbol_framer_if.slave bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    asm_q, asm_d;
    logic            asm_err_q, asm_err_d;
    logic [W-1:0]    out_q;
    logic            valid_q;
    logic            err_q;
    logic            abort_q, abort_d;
    logic            accept;
    logic            illegal;
    logic            xfer;
    logic            load;

    assign bus.sym_ready   = (state_q != FULL);
    assign accept          = bus.sym_valid & bus.sym_ready;
    // 01 and 10 are the only legal codes; equal bits mean a corrupted symbol.
    assign illegal         = (bus.sym_in[1] == bus.sym_in[0]);
    assign xfer            = valid_q & bus.frame_ready;

    assign bus.frame_out   = out_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_err   = err_q;
    assign bus.frame_abort = abort_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        asm_d     = asm_q;
        asm_err_d = asm_err_q;
        abort_d   = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                // Symbols arriving before a frame_start belong to no frame and are dropped.
                if (accept && bus.frame_start) begin
                    asm_d     = W'(bus.sym_in);
                    asm_err_d = illegal;
                    count_d   = CW'(1);
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (bus.frame_start) begin
                        // Restart: old partial frame is thrown away and reported once.
                        asm_d     = W'(bus.sym_in);
                        asm_err_d = illegal;
                        count_d   = CW'(1);
                        abort_d   = 1'b1;
                    end else begin
                        for (int k = 0; k < N; k++) begin
                            if (count_q == CW'(k)) begin
                                asm_d[2*k +: 2] = bus.sym_in;
                            end
                        end
                        asm_err_d = asm_err_q | illegal;
                        count_d   = count_q + 1'b1;
                        if (count_q == CW'(N - 1)) begin
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                // The output buffer is free if empty or being drained this very cycle,
                // which lets consecutive frames leave without a bubble.
                load = !valid_q || xfer;
                if (load) begin
                    count_d   = '0;
                    asm_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            asm_q     <= '0;
            asm_err_q <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            asm_q     <= asm_d;
            asm_err_q <= asm_err_d;
            abort_q   <= abort_d;
            if (load) begin
                out_q   <= asm_q;
                err_q   <= asm_err_q;
                valid_q <= 1'b1;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bpsk_symbol_framer.sv
// tb/tb_bpsk_symbol_framer.sv - self-checking bench for bpsk_symbol_framer (N=12 and N=15 instances)
module tb_bpsk_symbol_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  sym_in      [2];
    logic        sym_valid   [2];
    logic        frame_start [2];
    logic        frame_ready [2];
    logic        sym_ready_w   [2];
    logic        frame_valid_w [2];
    logic        frame_err_w   [2];
    logic        frame_abort_w [2];
    logic [29:0] frame_out_w   [2];

    int checks = 0;
    int errors = 0;
    bit rnd_mode = 1'b0;

    // Reference model state, one slot per instance.
    int          part_cnt  [2];
    logic [29:0] part_word [2];
    logic        part_err  [2];
    logic [29:0] exp_word  [2][$];
    logic        exp_err   [2][$];
    int          abort_exp [2];
    int          abort_seen[2];

    bpsk_symbol_framer_if #(.N(12)) bus12 ();
    bpsk_symbol_framer_if #(.N(15)) bus15 ();

    bpsk_symbol_framer #(.N(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));
    bpsk_symbol_framer #(.N(15)) dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

    assign bus12.sym_in      = sym_in[0];
    assign bus12.sym_valid   = sym_valid[0];
    assign bus12.frame_start = frame_start[0];
    assign bus12.frame_ready = frame_ready[0];
    assign bus15.sym_in      = sym_in[1];
    assign bus15.sym_valid   = sym_valid[1];
    assign bus15.frame_start = frame_start[1];
    assign bus15.frame_ready = frame_ready[1];

    assign sym_ready_w[0]   = bus12.sym_ready;
    assign frame_valid_w[0] = bus12.frame_valid;
    assign frame_err_w[0]   = bus12.frame_err;
    assign frame_abort_w[0] = bus12.frame_abort;
    assign frame_out_w[0]   = 30'(bus12.frame_out);
    assign sym_ready_w[1]   = bus15.sym_ready;
    assign frame_valid_w[1] = bus15.frame_valid;
    assign frame_err_w[1]   = bus15.frame_err;
    assign frame_abort_w[1] = bus15.frame_abort;
    assign frame_out_w[1]   = bus15.frame_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int n_of(input int d);
        return (d == 0) ? 12 : 15;
    endfunction

    function automatic logic [1:0] rnd_sym();
        if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
        return ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [29:0] rnd_word(input int n);
        logic [29:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[2*k +: 2] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        return w;
    endfunction

    // Monitor and model, sampled mid-cycle: what is seen here is what the next edge acts on.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                part_cnt[d]  = 0;
                part_word[d] = '0;
                part_err[d]  = 1'b0;
                exp_word[d].delete();
                exp_err[d].delete();
            end else begin
                if (frame_abort_w[d]) abort_seen[d]++;
                if (frame_valid_w[d]) begin
                    check($sformatf("frame_expected%0d", d), 32'(exp_word[d].size() != 0), 32'd1);
                    if (exp_word[d].size() != 0) begin
                        check($sformatf("frame_out%0d", d), 32'(frame_out_w[d]), 32'(exp_word[d][0]));
                        check($sformatf("frame_err%0d", d), 32'(frame_err_w[d]), 32'(exp_err[d][0]));
                        if (frame_ready[d]) begin
                            void'(exp_word[d].pop_front());
                            void'(exp_err[d].pop_front());
                        end
                    end
                end
                if (sym_valid[d] && sym_ready_w[d]) begin
                    if (frame_start[d]) begin
                        if (part_cnt[d] > 0) abort_exp[d]++;
                        part_cnt[d]  = 1;
                        part_word[d] = 30'(sym_in[d]);
                        part_err[d]  = (sym_in[d] == 2'b00) || (sym_in[d] == 2'b11);
                    end else if (part_cnt[d] > 0) begin
                        part_word[d] = part_word[d] | (30'(sym_in[d]) << (2 * part_cnt[d]));
                        part_err[d]  = part_err[d] | (sym_in[d] == 2'b00) | (sym_in[d] == 2'b11);
                        part_cnt[d]++;
                    end
                    if (part_cnt[d] == n_of(d)) begin
                        exp_word[d].push_back(part_word[d]);
                        exp_err[d].push_back(part_err[d]);
                        part_cnt[d] = 0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_mode) begin
            frame_ready[0] = ($urandom_range(0, 3) != 0);
            frame_ready[1] = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input logic [1:0] s, input logic st);
        int guard;
        guard = 0;
        sym_in[d]      = s;
        frame_start[d] = st;
        sym_valid[d]   = 1'b1;
        while (!sym_ready_w[d] && guard < 200) begin
            cyc(1);
            guard++;
        end
        if (guard >= 200) check("sym_ready_wait", 32'(sym_ready_w[d]), 32'd1);
        cyc(1);
        sym_valid[d]   = 1'b0;
        frame_start[d] = 1'b0;
    endtask

    task automatic send_frame(input int d, input logic [29:0] w, input int n);
        for (int k = 0; k < n; k++) send(d, w[2*k +: 2], k == 0);
    endtask

    task automatic wait_valid(input int d);
        int guard;
        guard = 0;
        while (!frame_valid_w[d] && guard < 50) begin
            cyc(1);
            guard++;
        end
        if (guard >= 50) check("frame_valid_wait", 32'(frame_valid_w[d]), 32'd1);
    endtask

    logic [29:0] wa, wb;
    int          a0, p;

    initial begin
        for (int d = 0; d < 2; d++) begin
            sym_in[d] = 2'b01; sym_valid[d] = 1'b0; frame_start[d] = 1'b0; frame_ready[d] = 1'b1;
            abort_exp[d] = 0; abort_seen[d] = 0;
        end
        rst_n = 1'b0;
        cyc(3);
        check("rst_sym_ready", 32'(sym_ready_w[0]), 32'd1);
        check("rst_frame_valid", 32'(frame_valid_w[0]), 32'd0);
        check("rst_frame_out", 32'(frame_out_w[0]), 32'd0);
        check("rst_frame_err", 32'(frame_err_w[0]), 32'd0);
        check("rst_frame_abort", 32'(frame_abort_w[0]), 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Alternating 01/10 frame and its output timing.
        send_frame(0, 30'h999999, 12);
        check("full_sym_ready", 32'(sym_ready_w[0]), 32'd0);
        check("full_frame_valid", 32'(frame_valid_w[0]), 32'd0);
        cyc(1);
        check("load_frame_valid", 32'(frame_valid_w[0]), 32'd1);
        check("load_frame_out", 32'(frame_out_w[0]), 32'h999999);
        check("load_frame_err", 32'(frame_err_w[0]), 32'd0);
        check("idle_sym_ready", 32'(sym_ready_w[0]), 32'd1);
        cyc(1);
        check("one_cycle_valid", 32'(frame_valid_w[0]), 32'd0);

        // Back-pressure: two frames, the second waits in FULL and loads in the drain cycle.
        wa = rnd_word(12);
        wb = rnd_word(12);
        frame_ready[0] = 1'b0;
        send_frame(0, wa, 12);
        send_frame(0, wb, 12);
        cyc(3);
        check("stall_sym_ready", 32'(sym_ready_w[0]), 32'd0);
        check("stall_frame_valid", 32'(frame_valid_w[0]), 32'd1);
        check("held_frame_out", 32'(frame_out_w[0]), 32'(wa));
        frame_ready[0] = 1'b1;
        cyc(1);
        check("b2b_frame_valid", 32'(frame_valid_w[0]), 32'd1);
        check("b2b_frame_out", 32'(frame_out_w[0]), 32'(wb));
        check("b2b_sym_ready", 32'(sym_ready_w[0]), 32'd1);
        cyc(1);
        check("b2b_drained", 32'(frame_valid_w[0]), 32'd0);

        // Illegal symbol in slot 5, then a clean frame.
        send_frame(0, 30'h555D55, 12);
        wait_valid(0);
        check("illegal_frame_out", 32'(frame_out_w[0]), 32'h555D55);
        check("illegal_frame_err", 32'(frame_err_w[0]), 32'd1);
        cyc(1);
        send_frame(0, 30'h555555, 12);
        wait_valid(0);
        check("clean_frame_err", 32'(frame_err_w[0]), 32'd0);
        cyc(1);

        // Restart after 7 symbols.
        a0 = abort_seen[0];
        wa = rnd_word(12);
        for (int k = 0; k < 7; k++) send(0, 2'b10, k == 0);
        send_frame(0, wa, 12);
        wait_valid(0);
        check("restart_frame_out", 32'(frame_out_w[0]), 32'(wa));
        check("abort_pulses", 32'(abort_seen[0] - a0), 32'd1);
        cyc(2);

        // Stray symbols in IDLE, then reset with 9 symbols collected.
        for (int k = 0; k < 5; k++) send(0, 2'b01, 1'b0);
        for (int k = 0; k < 9; k++) send(0, 2'b10, k == 0);
        rst_n = 1'b0;
        cyc(1);
        check("midrst_sym_ready", 32'(sym_ready_w[0]), 32'd1);
        check("midrst_frame_valid", 32'(frame_valid_w[0]), 32'd0);
        check("midrst_frame_out", 32'(frame_out_w[0]), 32'd0);
        check("midrst_frame_abort", 32'(frame_abort_w[0]), 32'd0);
        rst_n = 1'b1;
        cyc(20);
        check("post_rst_no_frame", 32'(frame_valid_w[0]), 32'd0);

        // Randomized traffic with gaps, restarts, illegal codes and random back-pressure.
        rnd_mode = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int f = 0; f < 10; f++) begin
                if ($urandom_range(0, 4) == 0) begin
                    p = $urandom_range(1, n_of(d) - 1);
                    for (int k = 0; k < p; k++) send(d, rnd_sym(), k == 0);
                end
                for (int k = 0; k < n_of(d); k++) begin
                    send(d, rnd_sym(), k == 0);
                    cyc($urandom_range(0, 2));
                end
            end
        end
        rnd_mode = 1'b0;
        cyc(1);
        frame_ready[0] = 1'b1;
        frame_ready[1] = 1'b1;
        cyc(60);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("drained%0d", d), 32'(exp_word[d].size()), 32'd0);
            check($sformatf("abort_count%0d", d), 32'(abort_seen[d]), 32'(abort_exp[d]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
